soft_reset_sequencer: RTL and testbench

- Control-unit side of the processor reset path: generates the reset that feeds the control-unit input of the reset mux once power-on reset has handed over.
- Takes a reset request from instruction decode and stalls fetch until the pipeline drains or a timeout expires.
- Drives a fixed-length reset pulse, holds fetch for a settling gap, then acknowledges.
- Also records the cause of the reset and keeps a saturating count of completed soft resets.

---
 rtl/soft_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_soft_reset_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/soft_reset_sequencer.sv
// Control-unit soft reset sequencer: drains the pipeline, pulses the reset-mux input,
// holds fetch for a settling gap, then acknowledges. Records cause and a saturating count.
//
// state    | meaning
// S_IDLE   | waiting for a request edge
// S_DRAIN  | fetch held, waiting for pipe idle or drain timeout
// S_ASSERT | reset pulse driven for HOLD_CYCLES
// S_STAGE  | reset released, fetch still held for STAGE_GAP
// S_ACK    | one-cycle completion acknowledge
module soft_reset_sequencer #(
  parameter int HOLD_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int STAGE_GAP     = 2,
  parameter int CNT_W         = 8
) (
  input  logic             srst_clk,
  input  logic             srst_rst_n,
  input  logic             srst_req,
  input  logic [1:0]       srst_cause,
  input  logic             srst_pipe_idle,
  input  logic             srst_clr,
  output logic             srst_rst_out,
  output logic             srst_fetch_hold,
  output logic             srst_busy,
  output logic             srst_ack,
  output logic [1:0]       srst_cause_q,
  output logic             srst_timeout,
  output logic             srst_drop,
  output logic [CNT_W-1:0] srst_count
);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ASSERT, S_STAGE, S_ACK} state_t;

  localparam logic [7:0] DRAIN_LD = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STAGE_LD = 8'(STAGE_GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       req_q, req_blk_q, req_edge, drain_to;

  logic             rst_out_d, fetch_hold_d, busy_d, ack_d, timeout_d, drop_d;
  logic [1:0]       cause_d;
  logic [CNT_W-1:0] count_d;

  // A request still high when reset releases must drop low once before it can be accepted.
  assign req_edge = srst_req & ~req_q & ~req_blk_q;

  always_ff @(posedge srst_clk) begin
    if (!srst_rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      req_q     <= 1'b0;
      req_blk_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= srst_req;
      if (!srst_req) req_blk_q <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    drain_to = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_edge) begin
          state_d = S_DRAIN;
          timer_d = DRAIN_LD;
        end
      end
      S_DRAIN: begin
        if (srst_pipe_idle || timer_q == 8'd0) begin
          drain_to = ~srst_pipe_idle;
          state_d  = S_ASSERT;
          timer_d  = HOLD_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_ASSERT: begin
        if (timer_q == 8'd0) begin
          state_d = S_STAGE;
          timer_d = STAGE_LD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_STAGE: begin
        if (timer_q == 8'd0) state_d = S_ACK;
        else timer_d = timer_q - 8'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with it.
  always_comb begin
    rst_out_d    = (state_d == S_ASSERT);
    fetch_hold_d = (state_d == S_DRAIN) || (state_d == S_ASSERT) || (state_d == S_STAGE);
    busy_d       = (state_d != S_IDLE);
    ack_d        = (state_d == S_ACK);
    cause_d      = (state_q == S_IDLE && req_edge) ? srst_cause : srst_cause_q;
    timeout_d    = srst_clr ? 1'b0 : srst_timeout;
    drop_d       = srst_clr ? 1'b0 : srst_drop;
    if (drain_to) timeout_d = 1'b1;
    if (req_edge && state_q != S_IDLE) drop_d = 1'b1;
    count_d = srst_count;
    if (state_d == S_ACK && srst_count != {CNT_W{1'b1}}) count_d = srst_count + CNT_W'(1);
  end

  always_ff @(posedge srst_clk) begin
    if (!srst_rst_n) begin
      srst_rst_out    <= 1'b0;
      srst_fetch_hold <= 1'b0;
      srst_busy       <= 1'b0;
      srst_ack        <= 1'b0;
      srst_cause_q    <= 2'b00;
      srst_timeout    <= 1'b0;
      srst_drop       <= 1'b0;
      srst_count      <= '0;
    end else begin
      srst_rst_out    <= rst_out_d;
      srst_fetch_hold <= fetch_hold_d;
      srst_busy       <= busy_d;
      srst_ack        <= ack_d;
      srst_cause_q    <= cause_d;
      srst_timeout    <= timeout_d;
      srst_drop       <= drop_d;
      srst_count      <= count_d;
    end
  end

endmodule

// File: tb/tb_soft_reset_sequencer.sv
// Bench for soft_reset_sequencer: directed plus random stimulus tables, expected outputs
// derived from per-request time windows (drain end, pulse, gap, ack) computed up front.
module tb_soft_reset_sequencer;

  localparam int H    = 4;
  localparam int DT   = 16;
  localparam int G    = 2;
  localparam int N    = 2400;
  localparam int NMAX = N + 64;

  logic       srst_clk = 1'b0;
  logic       srst_rst_n = 1'b0, srst_req = 1'b0, srst_pipe_idle = 1'b1, srst_clr = 1'b0;
  logic [1:0] srst_cause = 2'b00;
  logic       rst_out, fetch_hold, busy, ack, timeout, drop;
  logic [1:0] cause_q, cnt2;
  logic [7:0] cnt8;
  logic       s_rst_out, s_fetch_hold, s_busy, s_ack, s_timeout, s_drop;
  logic [1:0] s_cause_q;

  always #5 srst_clk = ~srst_clk;

  soft_reset_sequencer dut (
    .srst_clk(srst_clk), .srst_rst_n(srst_rst_n), .srst_req(srst_req),
    .srst_cause(srst_cause), .srst_pipe_idle(srst_pipe_idle), .srst_clr(srst_clr),
    .srst_rst_out(rst_out), .srst_fetch_hold(fetch_hold), .srst_busy(busy),
    .srst_ack(ack), .srst_cause_q(cause_q), .srst_timeout(timeout),
    .srst_drop(drop), .srst_count(cnt8));

  soft_reset_sequencer #(.CNT_W(2)) dut_sat (
    .srst_clk(srst_clk), .srst_rst_n(srst_rst_n), .srst_req(srst_req),
    .srst_cause(srst_cause), .srst_pipe_idle(srst_pipe_idle), .srst_clr(srst_clr),
    .srst_rst_out(s_rst_out), .srst_fetch_hold(s_fetch_hold), .srst_busy(s_busy),
    .srst_ack(s_ack), .srst_cause_q(s_cause_q), .srst_timeout(s_timeout),
    .srst_drop(s_drop), .srst_count(cnt2));

  bit       a_rstn [NMAX];
  bit       a_req  [NMAX];
  bit       a_idle [NMAX];
  bit       a_clr  [NMAX];
  bit [1:0] a_cause[NMAX];
  bit       x_rst[NMAX], x_hold[NMAX], x_busy[NMAX], x_ack[NMAX], x_to[NMAX], x_drop[NMAX];
  bit [1:0] x_cause[NMAX];
  int       x_c8[NMAX], x_c2[NMAX];

  int ptr = 0;
  int cur_k = 0;
  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cur_k, got, exp);
    end
  endtask

  task automatic put(input bit rn, input bit rq, input bit pi, input bit cl,
                     input bit [1:0] cs, input int n);
    for (int i = 0; i < n; i++) begin
      a_rstn[ptr] = rn; a_req[ptr] = rq; a_idle[ptr] = pi;
      a_clr[ptr] = cl; a_cause[ptr] = cs;
      ptr++;
    end
  endtask

  // Expected value after each clock edge k, from the windows of the accepted request:
  // DRAIN from edge s, ASSERT from edge a for H edges, STAGE for G edges, ACK at edge e.
  task automatic build_model();
    bit in_seq = 0, to_pend = 0, rq_prev = 0, blk = 1, to = 0, dr = 0, busy_prev, edge_k;
    bit [1:0] cq = 0;
    int s = 0, a = 0, e = -1, c8 = 0, c2 = 0, m;
    for (int k = 0; k < N; k++) begin
      if (!a_rstn[k]) begin
        in_seq = 0; rq_prev = 0; blk = 1; to = 0; dr = 0; cq = 0; c8 = 0; c2 = 0;
      end else begin
        busy_prev = in_seq && (k - 1 <= e);
        edge_k    = a_req[k] && !rq_prev && !blk;
        rq_prev   = a_req[k];
        if (!a_req[k]) blk = 0;
        if (a_clr[k]) begin to = 0; dr = 0; end
        if (edge_k && busy_prev) dr = 1;
        else if (edge_k) begin
          in_seq = 1; s = k; cq = a_cause[k]; m = 0; to_pend = 0;
          while (!a_idle[k + 1 + m] && m < DT - 1) m++;
          to_pend = !a_idle[k + 1 + m];
          a = k + 1 + m;
          e = a + H + G;
        end
        if (in_seq && k == a && to_pend) to = 1;
        if (in_seq && k == e) begin
          if (c8 < 255) c8++;
          if (c2 < 3) c2++;
        end
      end
      x_busy[k]  = a_rstn[k] && in_seq && k >= s && k <= e;
      x_hold[k]  = a_rstn[k] && in_seq && k >= s && k < e;
      x_rst[k]   = a_rstn[k] && in_seq && k >= a && k < a + H;
      x_ack[k]   = a_rstn[k] && in_seq && k == e;
      x_to[k] = to; x_drop[k] = dr; x_cause[k] = cq; x_c8[k] = c8; x_c2[k] = c2;
    end
  endtask

  initial begin
    // reset with request held, then release with it still held
    put(0, 1, 1, 0, 2'd0, 2);
    put(1, 1, 1, 0, 2'd0, 4);
    put(1, 0, 1, 0, 2'd0, 2);
    // nominal request, cause 2'b10
    put(1, 1, 1, 0, 2'd2, 1);
    put(1, 0, 1, 0, 2'd0, 12);
    // drain wait of 5 busy cycles
    put(1, 1, 0, 0, 2'd1, 1);
    put(1, 0, 0, 0, 2'd0, 5);
    put(1, 0, 1, 0, 2'd0, 14);
    // drain timeout, then clear
    put(1, 1, 0, 0, 2'd3, 1);
    put(1, 0, 0, 0, 2'd0, 30);
    put(1, 0, 0, 1, 2'd0, 1);
    put(1, 0, 1, 0, 2'd0, 2);
    // dropped edges during ASSERT and during ACK, then clear with a same-cycle edge
    put(1, 1, 1, 0, 2'd1, 1);
    put(1, 0, 1, 0, 2'd0, 2);
    put(1, 1, 1, 0, 2'd0, 1);
    put(1, 0, 1, 0, 2'd0, 4);
    put(1, 1, 1, 0, 2'd0, 1);
    put(1, 0, 1, 0, 2'd0, 3);
    put(1, 1, 1, 0, 2'd2, 1);
    put(1, 0, 1, 0, 2'd0, 2);
    put(1, 1, 1, 1, 2'd0, 1);
    put(1, 0, 1, 0, 2'd0, 10);
    // reset during the second ASSERT cycle
    put(1, 1, 1, 0, 2'd2, 1);
    put(1, 0, 1, 0, 2'd0, 2);
    put(0, 0, 1, 0, 2'd0, 1);
    put(1, 0, 1, 0, 2'd0, 4);
    // five back-to-back sequences for counter saturation
    for (int i = 0; i < 5; i++) begin
      put(1, 1, 1, 0, 2'(i), 1);
      put(1, 0, 1, 0, 2'd0, 8);
    end
    // random traffic
    begin
      bit rq = 0;
      int idle_bias = 3;
      while (ptr < NMAX) begin
        if ($urandom_range(0, 5) == 0) rq = ~rq;
        if ($urandom_range(0, 40) == 0) idle_bias = $urandom_range(0, 4);
        put(($urandom_range(0, 199) != 0), rq, ($urandom_range(0, 3) < idle_bias),
            ($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)), 1);
      end
    end

    build_model();

    for (int k = 0; k < N; k++) begin
      @(negedge srst_clk);
      srst_rst_n = a_rstn[k]; srst_req = a_req[k]; srst_pipe_idle = a_idle[k];
      srst_clr = a_clr[k]; srst_cause = a_cause[k];
      @(posedge srst_clk);
      #1;
      cur_k = k;
      check_val("rst_out",    int'(rst_out),    int'(x_rst[k]));
      check_val("fetch_hold", int'(fetch_hold), int'(x_hold[k]));
      check_val("busy",       int'(busy),       int'(x_busy[k]));
      check_val("ack",        int'(ack),        int'(x_ack[k]));
      check_val("cause_q",    int'(cause_q),    int'(x_cause[k]));
      check_val("timeout",    int'(timeout),    int'(x_to[k]));
      check_val("drop",       int'(drop),       int'(x_drop[k]));
      check_val("count",      int'(cnt8),       x_c8[k]);
      check_val("count_sat",  int'(cnt2),       x_c2[k]);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
